// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: default widths, test-trigger
// period default and the sequencer state encoding.
package capture_pkg;

    localparam int CAP_CNT_W           = 16;
    localparam int CAP_RGN_W           = 4;
    localparam int CAP_TEST_PERIOD_DEF = 'hF906;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ENA_WAIT   = 2'd1,
        ST_START_WAIT = 2'd2,
        ST_CAPTURE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/capture_test_trig.sv
// Free-running internal trigger generator: counts 0..period and pulses at 0.
// The period input is sampled only when the counter wraps.
module capture_test_trig import capture_pkg::*; #(
    parameter int               CNT_W      = CAP_CNT_W,
    parameter logic [CNT_W-1:0] PERIOD_DEF = CNT_W'(CAP_TEST_PERIOD_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] test_period,
    output logic             test_trig
);

    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] period_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            period_q <= PERIOD_DEF;
        end else if (tick_cnt == period_q) begin
            tick_cnt <= '0;
            period_q <= test_period;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign test_trig = (tick_cnt == '0);

endmodule

// File: rtl/capture_sequencer.sv
// ADC capture sequencer: trigger -> enable delay -> start delay -> a run of
// regions whose sample counts come from a writable size table.
module capture_sequencer import capture_pkg::*; #(
    parameter int               CNT_W           = CAP_CNT_W,
    parameter int               RGN_W           = CAP_RGN_W,
    parameter logic [CNT_W-1:0] TEST_PERIOD_DEF = CNT_W'(CAP_TEST_PERIOD_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             test_mode,
    input  logic [CNT_W-1:0] test_period,
    input  logic [CNT_W-1:0] ena_delay,
    input  logic [CNT_W-1:0] start_delay,
    input  logic [RGN_W:0]   cap_regions,
    input  logic             size_we,
    input  logic [RGN_W-1:0] size_addr,
    input  logic [CNT_W-1:0] size_data,
    input  logic             abort,
    output logic             cap_ena,
    output logic             cap_start,
    output logic [RGN_W-1:0] cap_region,
    output logic             region_end,
    output logic             end_cycle,
    output logic             busy,
    output logic             trig_overrun
);

    localparam int NUM_RGN = 2 ** RGN_W;

    // Zero-length delays and sizes behave as one clock / one sample.
    function automatic logic [CNT_W:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? (CNT_W+1)'(1) : {1'b0, v};
    endfunction

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ena_lat, ena_d;
    logic [CNT_W-1:0] start_lat, start_d;
    logic [RGN_W:0]   regions_lat, regions_d, regions_eff;
    logic [RGN_W-1:0] region_q, region_d, region_inc;
    logic [CNT_W:0]   size_q, size_d;
    logic [CNT_W-1:0] size_tbl [NUM_RGN];

    logic             test_trig_raw, trig_any;
    logic             cap_ena_d, cap_start_d, region_end_d, end_cycle_d;
    logic             busy_d, overrun_d;
    logic [RGN_W-1:0] cap_region_d;

    capture_test_trig #(
        .CNT_W      (CNT_W),
        .PERIOD_DEF (TEST_PERIOD_DEF)
    ) u_test_trig (
        .clk         (clk),
        .rst_n       (rst_n),
        .test_period (test_period),
        .test_trig   (test_trig_raw)
    );

    assign trig_any   = trig | (test_trig_raw & test_mode);
    assign region_inc = region_q + 1'b1;

    always_comb begin
        if (cap_regions == '0)
            regions_eff = (RGN_W+1)'(1);
        else if (cap_regions > (RGN_W+1)'(NUM_RGN))
            regions_eff = (RGN_W+1)'(NUM_RGN);
        else
            regions_eff = cap_regions;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ena_d     = ena_lat;
        start_d   = start_lat;
        regions_d = regions_lat;
        region_d  = region_q;
        size_d    = size_q;
        overrun_d = 1'b0;

        if (abort) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            region_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig_any) begin
                        state_d   = ST_ENA_WAIT;
                        cnt_d     = '0;
                        ena_d     = ena_delay;
                        start_d   = start_delay;
                        regions_d = regions_eff;
                    end
                end
                ST_ENA_WAIT: begin
                    overrun_d = trig_any;
                    if (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= at_least_one(ena_lat)) begin
                        state_d = ST_START_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_START_WAIT: begin
                    overrun_d = trig_any;
                    if (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= at_least_one(start_lat)) begin
                        state_d  = ST_CAPTURE;
                        cnt_d    = '0;
                        region_d = '0;
                        size_d   = at_least_one(size_tbl[0]);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    overrun_d = trig_any;
                    if (({1'b0, cnt_q} + (CNT_W+1)'(1)) == size_q) begin
                        cnt_d = '0;
                        if (({1'b0, region_q} + (RGN_W+1)'(1)) == regions_lat) begin
                            state_d  = ST_IDLE;
                            region_d = '0;
                        end else begin
                            region_d = region_inc;
                            size_d   = at_least_one(size_tbl[region_inc]);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they can leave flops.
        cap_ena_d    = (state_d == ST_START_WAIT) || (state_d == ST_CAPTURE);
        cap_start_d  = (state_d == ST_CAPTURE) && (cnt_d == '0);
        region_end_d = (state_d == ST_CAPTURE) &&
                       (({1'b0, cnt_d} + (CNT_W+1)'(1)) == size_d);
        end_cycle_d  = region_end_d &&
                       (({1'b0, region_d} + (RGN_W+1)'(1)) == regions_d);
        cap_region_d = (state_d == ST_CAPTURE) ? region_d : '0;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ena_lat      <= '0;
            start_lat    <= '0;
            regions_lat  <= '0;
            region_q     <= '0;
            size_q       <= '0;
            cap_ena      <= 1'b0;
            cap_start    <= 1'b0;
            cap_region   <= '0;
            region_end   <= 1'b0;
            end_cycle    <= 1'b0;
            busy         <= 1'b0;
            trig_overrun <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ena_lat      <= ena_d;
            start_lat    <= start_d;
            regions_lat  <= regions_d;
            region_q     <= region_d;
            size_q       <= size_d;
            cap_ena      <= cap_ena_d;
            cap_start    <= cap_start_d;
            cap_region   <= cap_region_d;
            region_end   <= region_end_d;
            end_cycle    <= end_cycle_d;
            busy         <= busy_d;
            trig_overrun <= overrun_d;
        end
    end

    // Sizes are sampled at region start, so a write landing on that same
    // edge is seen only from the following region start onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RGN; i++)
                size_tbl[i] <= CNT_W'(1);
        end else if (size_we) begin
            size_tbl[size_addr] <= size_data;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios plus random traffic, all
// checked cycle by cycle against a timeline model of the capture cycle.
module tb_capture_sequencer;

    localparam int CNT_W         = 16;
    localparam int RGN_W         = 4;
    localparam int NUM_RGN       = 16;
    localparam int TB_PERIOD_DEF = 49;

    logic             clk, rst_n, trig, test_mode, size_we, abort;
    logic [CNT_W-1:0] test_period, ena_delay, start_delay, size_data;
    logic [RGN_W:0]   cap_regions;
    logic [RGN_W-1:0] size_addr, cap_region;
    logic             cap_ena, cap_start, region_end, end_cycle, busy, trig_overrun;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];

    // timeline model
    bit m_busy;
    int m_t_ena, m_t_cap, m_first, m_len, m_rgn, m_regions;
    int m_size[NUM_RGN];
    int m_tick, m_wrap, m_per, edge_n;

    // observations of the DUT
    int cur_e, ena_rise_e, end_e, start_e, last_len, len_r1, n_end, n_ovr;
    bit prev_ena, prev_busy, triple_seen;
    int start_log[$];
    int acc_log[$];
    int acc, e0, o0;

    capture_sequencer #(
        .CNT_W           (CNT_W),
        .RGN_W           (RGN_W),
        .TEST_PERIOD_DEF (16'd49)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig         (trig),
        .test_mode    (test_mode),
        .test_period  (test_period),
        .ena_delay    (ena_delay),
        .start_delay  (start_delay),
        .cap_regions  (cap_regions),
        .size_we      (size_we),
        .size_addr    (size_addr),
        .size_data    (size_data),
        .abort        (abort),
        .cap_ena      (cap_ena),
        .cap_start    (cap_start),
        .cap_region   (cap_region),
        .region_end   (region_end),
        .end_cycle    (end_cycle),
        .busy         (busy),
        .trig_overrun (trig_overrun)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int at1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        for (int i = 0; i < NUM_RGN; i++) m_size[i] = 1;
        m_per  = TB_PERIOD_DEF;
        m_tick = 0;
        m_wrap = -1;
        edge_n = 0;
        exp_q.delete();
        prev_ena  = 1'b0;
        prev_busy = 1'b0;
    endtask

    // One clock edge of the reference: every event is a point on a timeline
    // of edge numbers computed from the latched delays and sizes.
    task automatic model_edge();
        bit tt, tin, ovr, capt, e_ena, e_start, e_rend, e_end;
        logic [3:0] e_rgn;
        tt = (edge_n == m_tick);
        if (tt) m_wrap = edge_n + m_per;
        if (edge_n == m_wrap) begin
            m_per  = int'(test_period);
            m_tick = edge_n + 1;
        end
        tin = trig || (test_mode && tt);
        ovr = 1'b0;
        if (abort) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (tin) begin
                m_busy    = 1'b1;
                m_t_ena   = edge_n + at1(int'(ena_delay));
                m_t_cap   = m_t_ena + at1(int'(start_delay));
                m_regions = (cap_regions == 0) ? 1 : ((int'(cap_regions) > NUM_RGN) ? NUM_RGN : int'(cap_regions));
            end
        end else begin
            ovr = tin;
            if (edge_n == m_t_cap) begin
                m_rgn   = 0;
                m_first = edge_n;
                m_len   = at1(m_size[0]);
            end else if (edge_n > m_t_cap && edge_n == m_first + m_len) begin
                if (m_rgn == m_regions - 1) begin
                    m_busy = 1'b0;
                end else begin
                    m_rgn   = m_rgn + 1;
                    m_first = edge_n;
                    m_len   = at1(m_size[m_rgn]);
                end
            end
        end
        if (size_we) m_size[size_addr] = int'(size_data);
        capt    = m_busy && edge_n >= m_t_cap;
        e_ena   = m_busy && edge_n >= m_t_ena;
        e_start = capt && edge_n == m_first;
        e_rend  = capt && edge_n == m_first + m_len - 1;
        e_end   = e_rend && m_rgn == m_regions - 1;
        e_rgn   = capt ? 4'(m_rgn) : 4'd0;
        exp_q.push_back({e_ena, e_start, e_rgn, e_rend, e_end, m_busy, ovr});
        edge_n++;
    endtask

    // driver: one clock with current inputs, then scoreboard compare
    task automatic step();
        logic [9:0] got, exp;
        @(posedge clk);
        model_edge();
        cur_e = edge_n - 1;
        #1;
        got = {cap_ena, cap_start, cap_region, region_end, end_cycle, busy, trig_overrun};
        exp = exp_q.pop_front();
        check("outputs", 32'(got), 32'(exp));
        if (cap_ena && !prev_ena) ena_rise_e = cur_e;
        if (busy && !prev_busy) acc_log.push_back(cur_e);
        prev_ena  = cap_ena;
        prev_busy = busy;
        if (cap_start) begin
            start_e = cur_e;
            start_log.push_back(cur_e);
        end
        if (region_end) begin
            last_len = cur_e - start_e + 1;
            if (cap_region == 4'd1) len_r1 = last_len;
        end
        if (end_cycle) begin
            end_e = cur_e;
            n_end++;
        end
        if (trig_overrun) n_ovr++;
        if (cap_start && region_end && end_cycle) triple_seen = 1'b1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic write_size(input int addr, input int data);
        size_addr = 4'(addr);
        size_data = 16'(data);
        size_we   = 1'b1;
        step();
        size_we   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) step();
        check(tag, 32'(busy), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0; trig = 1'b0; test_mode = 1'b0; abort = 1'b0;
        size_we = 1'b0; size_addr = '0; size_data = '0;
        test_period = 16'd99; ena_delay = 16'd64; start_delay = 16'd10;
        cap_regions = 5'd2;
        n_end = 0; n_ovr = 0; start_e = 0; last_len = 0; len_r1 = 0;
        ena_rise_e = -1; end_e = -1; triple_seen = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({cap_ena, cap_start, cap_region, region_end, end_cycle, busy, trig_overrun}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // basic cycle: 64 / 10 delays, two regions of 4 and 3 samples
        write_size(0, 4);
        write_size(1, 3);
        start_log.delete();
        pulse_trig();
        acc = cur_e;
        wait_idle("basic_idle", 200);
        check("basic_ena_rise", 32'(ena_rise_e - acc), 32'(64));
        check("basic_start_cnt", 32'(start_log.size()), 32'(2));
        if (start_log.size() >= 2) begin
            check("basic_start0", 32'(start_log[0] - acc), 32'(74));
            check("basic_start1", 32'(start_log[1] - acc), 32'(78));
        end
        check("basic_end", 32'(end_e - acc), 32'(80));

        // test mode, cycle shorter than the period
        ena_delay = 16'd5; start_delay = 16'd2;
        acc_log.delete();
        o0 = n_ovr;
        test_mode = 1'b1;
        repeat (420) step();
        check("test_accepts", 32'(acc_log.size() >= 4), 32'(1));
        for (int i = 1; i < acc_log.size(); i++)
            check("test_spacing", 32'(acc_log[i] - acc_log[i-1]), 32'(100));
        check("test_no_overrun", 32'(n_ovr - o0), 32'(0));

        // test mode, cycle longer than the period
        test_period = 16'd19; ena_delay = 16'd30;
        o0 = n_ovr;
        repeat (250) step();
        check("test_overrun_seen", 32'(n_ovr - o0 > 0), 32'(1));
        test_mode = 1'b0;
        wait_idle("test_idle", 200);

        // single 1-sample region
        write_size(0, 0);
        cap_regions = 5'd0; ena_delay = 16'd2; start_delay = 16'd1;
        triple_seen = 1'b0;
        pulse_trig();
        wait_idle("edge_idle", 50);
        check("edge_triple", 32'(triple_seen), 32'(1));

        // abort in region 1, with a simultaneous trigger, then immediate retrigger
        write_size(0, 4);
        write_size(1, 6);
        cap_regions = 5'd2;
        pulse_trig();
        for (int i = 0; i < 100 && cap_region != 4'd1; i++) step();
        check("abort_reach_rgn1", 32'(cap_region), 32'(1));
        step();
        e0 = n_end;
        abort = 1'b1; trig = 1'b1;
        step();
        abort = 1'b0; trig = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_ena", 32'(cap_ena), 32'(0));
        check("abort_no_end", 32'(n_end - e0), 32'(0));
        pulse_trig();
        check("abort_retrig", 32'(busy), 32'(1));
        wait_idle("abort_idle", 100);

        // async reset during START_WAIT
        ena_delay = 16'd3; start_delay = 16'd20;
        pulse_trig();
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({cap_ena, cap_start, cap_region, region_end, end_cycle, busy, trig_overrun}), 32'(0));
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ena_delay = 16'd2; start_delay = 16'd2; cap_regions = 5'd2;
        e0 = n_end;
        pulse_trig();
        wait_idle("recover_idle", 50);
        check("recover_end", 32'(n_end - e0), 32'(1));
        check("recover_size1", 32'(last_len), 32'(1));

        // size table update timing
        write_size(0, 3);
        write_size(1, 3);
        pulse_trig();
        for (int i = 0; i < 50 && !(cap_start && cap_region == 4'd0); i++) step();
        write_size(1, 5);
        wait_idle("upd0_idle", 50);
        check("upd_in_rgn0", 32'(len_r1), 32'(5));
        pulse_trig();
        for (int i = 0; i < 50 && !(cap_start && cap_region == 4'd1); i++) step();
        write_size(1, 2);
        wait_idle("upd1_idle", 50);
        check("upd_in_rgn1_old", 32'(len_r1), 32'(5));
        pulse_trig();
        wait_idle("upd2_idle", 50);
        check("upd_next_cycle", 32'(len_r1), 32'(2));

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                cap_regions = 5'($urandom_range(0, 31));
                ena_delay   = 16'($urandom_range(0, 4));
                start_delay = 16'($urandom_range(0, 4));
                test_mode   = 1'($urandom_range(0, 1));
                test_period = 16'($urandom_range(2, 25));
            end
            trig      = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 59) == 0);
            size_we   = ($urandom_range(0, 7) == 0);
            size_addr = 4'($urandom_range(0, 15));
            size_data = 16'($urandom_range(0, 5));
            step();
        end
        trig = 1'b0; abort = 1'b0; size_we = 1'b0; test_mode = 1'b0;
        wait_idle("random_idle", 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
